// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalization stage.
package hist_eq_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned PIX_LOG2_DEF   = 14;
    localparam int unsigned CNT_WIDTH_DEF  = PIX_LOG2_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_HIST  = 3'd2,
        ST_CDF   = 3'd3,
        ST_APPLY = 3'd4
    } state_t;

    // Number of histogram bins for a given pixel width.
    function automatic int unsigned pix_nbins(input int unsigned dw);
        return 32'(1) << dw;
    endfunction

    // LUT scaling constant: the largest representable pixel value.
    function automatic int unsigned lut_scale(input int unsigned dw);
        return pix_nbins(dw) - 32'(1);
    endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Histogram bin storage: single clock, registered read, one write port.
module hist_bin_ram
    import hist_eq_pkg::*;
#(
    parameter int unsigned DEPTH = pix_nbins(DATA_WIDTH_DEF),
    parameter int unsigned AW    = DATA_WIDTH_DEF,
    parameter int unsigned DW    = CNT_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port plus registered read; a same-address write is forwarded to the read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/hist_eq_unit.sv
// Histogram build, CDF-based LUT generation and pixel remapping over one frame.
module hist_eq_unit
    import hist_eq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PIX_LOG2   = PIX_LOG2_DEF,
    parameter int unsigned CNT_WIDTH  = PIX_LOG2 + 1
) (
    input  logic                  rClk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pixIn,
    input  logic                  pixValid,
    output logic [DATA_WIDTH-1:0] newPixel,
    output logic                  CDF_done,
    output logic                  calc_done,
    output logic                  busy
);

    localparam int unsigned NBINS      = pix_nbins(DATA_WIDTH);
    localparam int unsigned PIX_COUNT  = 32'(1) << PIX_LOG2;
    localparam int unsigned LUT_SCALE  = lut_scale(DATA_WIDTH);
    localparam int unsigned PROD_WIDTH = CNT_WIDTH + DATA_WIDTH;
    localparam int unsigned IDX_WIDTH  = DATA_WIDTH + 1;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   clr_idx;
    logic [IDX_WIDTH-1:0]    cdf_idx;
    logic [CNT_WIDTH-1:0]    pix_cnt;
    logic                    hist_wr_v;
    logic [DATA_WIDTH-1:0]   hist_addr_d;
    logic                    cdf_rd_v;
    logic [DATA_WIDTH-1:0]   cdf_addr_d;
    logic [CNT_WIDTH-1:0]    cdf_sum;

    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_waddr;
    logic [CNT_WIDTH-1:0]    ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_raddr;
    logic [CNT_WIDTH-1:0]    ram_rdata;

    logic [CNT_WIDTH-1:0]    cdf_sum_next;
    logic [PROD_WIDTH-1:0]   lut_prod;
    logic [DATA_WIDTH-1:0]   lut_val;

    logic [DATA_WIDTH-1:0]   lut [NBINS];

    hist_bin_ram #(
        .DEPTH (NBINS),
        .AW    (DATA_WIDTH),
        .DW    (CNT_WIDTH)
    ) u_bins (
        .clk   (rClk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Bin RAM port steering: CLEAR zeroes, HIST writes back read+1 one cycle after the read.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = pixIn;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
        end else if (hist_wr_v) begin
            ram_we    = 1'b1;
            ram_waddr = hist_addr_d;
            ram_wdata = ram_rdata + CNT_WIDTH'(1);
        end
        if (state == ST_CDF) begin
            ram_raddr = cdf_idx[DATA_WIDTH-1:0];
        end
    end

    // Inclusive running sum and its scaled LUT entry.
    always_comb begin
        cdf_sum_next = cdf_sum + ram_rdata;
        lut_prod     = PROD_WIDTH'(cdf_sum_next) * PROD_WIDTH'(LUT_SCALE);
        lut_val      = DATA_WIDTH'(lut_prod >> PIX_LOG2);
    end

    // LUT fill during the CDF walk; contents hold until the next walk.
    always_ff @(posedge rClk) begin
        if (cdf_rd_v) begin
            lut[cdf_addr_d] <= lut_val;
        end
    end

    // Control FSM, counters and registered outputs.
    always_ff @(posedge rClk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            clr_idx     <= '0;
            cdf_idx     <= '0;
            pix_cnt     <= '0;
            hist_wr_v   <= 1'b0;
            hist_addr_d <= '0;
            cdf_rd_v    <= 1'b0;
            cdf_addr_d  <= '0;
            cdf_sum     <= '0;
            newPixel    <= '0;
            CDF_done    <= 1'b0;
            calc_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hist_wr_v <= 1'b0;
            cdf_rd_v  <= 1'b0;

            if (state == ST_APPLY) begin
                newPixel <= pixValid ? lut[pixIn] : '0;
            end else begin
                newPixel <= pixValid ? pixIn : '0;
            end

            if (start) begin
                state     <= ST_CLEAR;
                clr_idx   <= '0;
                cdf_idx   <= '0;
                pix_cnt   <= '0;
                cdf_sum   <= '0;
                CDF_done  <= 1'b0;
                calc_done <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        if (clr_idx == DATA_WIDTH'(NBINS - 1)) begin
                            state   <= ST_HIST;
                            clr_idx <= '0;
                        end else begin
                            clr_idx <= clr_idx + DATA_WIDTH'(1);
                        end
                    end
                    ST_HIST: begin
                        if (pixValid) begin
                            hist_wr_v   <= 1'b1;
                            hist_addr_d <= pixIn;
                            if (pix_cnt == CNT_WIDTH'(PIX_COUNT - 1)) begin
                                pix_cnt <= '0;
                                cdf_idx <= '0;
                                cdf_sum <= '0;
                                state   <= ST_CDF;
                            end else begin
                                pix_cnt <= pix_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    ST_CDF: begin
                        if (!cdf_idx[DATA_WIDTH]) begin
                            cdf_rd_v   <= 1'b1;
                            cdf_addr_d <= cdf_idx[DATA_WIDTH-1:0];
                            cdf_idx    <= cdf_idx + IDX_WIDTH'(1);
                        end
                        if (cdf_rd_v) begin
                            cdf_sum <= cdf_sum_next;
                            if (cdf_addr_d == DATA_WIDTH'(NBINS - 1)) begin
                                CDF_done <= 1'b1;
                                busy     <= 1'b0;
                                state    <= ST_APPLY;
                            end
                        end
                    end
                    ST_APPLY: begin
                        if (pixValid && !calc_done) begin
                            if (pix_cnt == CNT_WIDTH'(PIX_COUNT - 1)) begin
                                calc_done <= 1'b1;
                            end else begin
                                pix_cnt <= pix_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hist_eq_unit.sv
// Scoreboard bench for hist_eq_unit, run with a reduced 1024-pixel frame.
module tb_hist_eq_unit;

    localparam int unsigned DW  = 8;
    localparam int unsigned PL  = 10;
    localparam int unsigned CW  = PL + 1;
    localparam int unsigned NB  = 256;
    localparam int unsigned PIX = 1 << PL;

    logic          clk;
    logic          rst;
    logic          start;
    logic          pix_valid;
    logic [DW-1:0] pix_in;
    logic [DW-1:0] new_pixel;
    logic          cdf_done;
    logic          calc_done;
    logic          busy;

    int            n_cmp;
    int            n_err;
    int            hist_m [NB];
    logic [7:0]    lut_m  [NB];
    logic [7:0]    exp_q  [$];

    hist_eq_unit #(
        .DATA_WIDTH (DW),
        .PIX_LOG2   (PL),
        .CNT_WIDTH  (CW)
    ) dut (
        .rClk      (clk),
        .rst       (rst),
        .start     (start),
        .pixIn     (pix_in),
        .pixValid  (pix_valid),
        .newPixel  (new_pixel),
        .CDF_done  (cdf_done),
        .calc_done (calc_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, optionally score newPixel at the next negedge.
    task automatic px(input bit s, input bit v, input logic [7:0] p, input bit chk, input logic [7:0] e);
        logic [7:0] want;
        start     = s;
        pix_valid = v;
        pix_in    = p;
        if (chk) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (chk) begin
            want = exp_q.pop_front();
            check("newPixel", 32'(new_pixel), 32'(want));
        end
    endtask

    function automatic logic [7:0] frame_pix(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'h40;
            default: return (i < int'(PIX / 2)) ? 8'h10 : 8'h20;
        endcase
    endfunction

    task automatic build_lut();
        longint sum;
        sum = 0;
        for (int i = 0; i < int'(NB); i++) begin
            sum += longint'(hist_m[i]);
            lut_m[i] = 8'((sum * 255) >> PL);
        end
    endtask

    // Start, CLEAR, one histogram frame and the CDF walk.
    task automatic run_frame(input int mode, input bit gaps);
        int         waited;
        logic [7:0] p;
        for (int i = 0; i < int'(NB); i++) hist_m[i] = 0;
        px(1'b1, 1'b1, 8'h99, 1'b0, 8'h00);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cdf_done", 32'(cdf_done), 32'd0);
        check("start_calc_done", 32'(calc_done), 32'd0);
        repeat (NB) px(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        check("clear_busy", 32'(busy), 32'd1);
        for (int i = 0; i < int'(PIX); i++) begin
            p = frame_pix(mode, i);
            hist_m[p]++;
            px(1'b0, 1'b1, p, 1'b0, 8'h00);
            if (gaps) px(1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00);
        end
        check("hist_busy", 32'(busy), 32'd1);
        waited = 0;
        while (!cdf_done && waited < 400) begin
            px(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
            waited++;
        end
        check("cdf_done", 32'(cdf_done), 32'd1);
        check("cdf_latency", 32'(waited >= 256 && waited <= 258), 32'd1);
        check("apply_busy", 32'(busy), 32'd0);
        check("calc_done_early", 32'(calc_done), 32'd0);
        build_lut();
    endtask

    // One full APPLY frame scored against the model LUT, with idle cycles mixed in.
    task automatic apply_frame();
        logic [7:0] p;
        for (int i = 0; i < int'(PIX) - 1; i++) begin
            p = 8'(i);
            if (i % 97 == 0) px(1'b0, 1'b0, p, 1'b1, 8'h00);
            px(1'b0, 1'b1, p, 1'b1, lut_m[p]);
        end
        check("calc_done_before_last", 32'(calc_done), 32'd0);
        px(1'b0, 1'b1, 8'hFF, 1'b1, lut_m[255]);
        check("calc_done_at_last", 32'(calc_done), 32'd1);
        px(1'b0, 1'b0, 8'h12, 1'b1, 8'h00);
        px(1'b0, 1'b1, 8'h80, 1'b1, lut_m[128]);
        check("calc_done_hold", 32'(calc_done), 32'd1);
        check("cdf_done_hold", 32'(cdf_done), 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        repeat (3) @(negedge clk);
        check("rst_newPixel", 32'(new_pixel), 32'd0);
        check("rst_cdf_done", 32'(cdf_done), 32'd0);
        check("rst_calc_done", 32'(calc_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // IDLE pass-through
        px(1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5);
        px(1'b0, 1'b0, 8'h5A, 1'b1, 8'h00);
        px(1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C);

        // Ramp frame: identity mapping
        run_frame(0, 1'b0);
        apply_frame();
        px(1'b0, 1'b1, 8'h37, 1'b1, 8'h37);
        px(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
        px(1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF);

        // Constant 0x40 frame, restarted from APPLY
        run_frame(1, 1'b0);
        apply_frame();
        px(1'b0, 1'b1, 8'h40, 1'b1, 8'hFF);
        px(1'b0, 1'b1, 8'h3F, 1'b1, 8'h00);
        px(1'b0, 1'b1, 8'h37, 1'b1, 8'h00);
        px(1'b0, 1'b0, 8'h40, 1'b1, 8'h00);

        // Half-dark frame with gaps between pixels
        run_frame(2, 1'b1);
        apply_frame();
        px(1'b0, 1'b1, 8'h10, 1'b1, 8'd127);
        px(1'b0, 1'b1, 8'h20, 1'b1, 8'hFF);
        px(1'b0, 1'b1, 8'h0F, 1'b1, 8'h00);

        // Reset in the middle of HIST
        px(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (NB) px(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) px(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_newPixel", 32'(new_pixel), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_cdf_done", 32'(cdf_done), 32'd0);
        check("async_rst_calc_done", 32'(calc_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        px(1'b0, 1'b1, 8'h66, 1'b1, 8'h66);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_frame(0, 1'b0);
        apply_frame();
        px(1'b0, 1'b1, 8'h37, 1'b1, 8'h37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
